// File: rtl/ram_loader_if.sv
// Word stream into ram_loader. A word moves on every clk edge where
// in_valid and in_ready are both high; in_data is only meaningful while in_valid=1.
interface ram_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ram_loader.sv
// Streams a counted block of words into a single-port-write block RAM at
// consecutive (wrapping) addresses, with an independent registered read port.
module ram_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    ram_loader_if.slave           in_if,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (len != '0) begin
                        waddr_d     = base;
                        remaining_d = len;
                        state_d     = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // abort wins over a simultaneous word: the word stays upstream
                if (abort) begin
                    state_d = IDLE;
                end else if (in_if.in_valid) begin
                    wr_en       = 1'b1;
                    waddr_d     = waddr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
                    count_d     = count_q + (ADDR_WIDTH + 1)'(1);
                    if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    // Memory contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr_q] <= in_if.in_data;
        end
    end

    always_comb begin
        q_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign in_if.in_ready = (state_q == LOAD);
    assign busy           = (state_q == LOAD);
    assign done           = done_q;
    assign count          = count_q;
    assign q              = q_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/ram_loader.md
# ram_loader

Streaming writer that fills an on-chip block RAM from a valid/ready word stream, the write-side counterpart of the team's synchronous-read ROM. A controller issues a start with a base address and word count. The block accepts that many words and writes them to consecutive addresses, wrapping at the top of memory. It then pulses done. The same memory is exposed through a registered read port, so downstream logic reads loaded data with one-cycle latency.

## Interface
- ADDR_WIDTH, default 9: memory address width; DEPTH = 1 << ADDR_WIDTH.
- DATA_WIDTH, default 8: word width of stream and memory.
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  load request, sampled only in IDLE.
- base  input  ADDR_WIDTH  first write address, sampled with start.
- len  input  ADDR_WIDTH+1  number of words to load (0..DEPTH), sampled with start.
- abort  input  1  terminates a load in progress.
- in_data  input  DATA_WIDTH  stream word.
- in_valid  input  1  stream word present.
- in_ready  output  1  block accepts a word this cycle.
- busy  output  1  high while in LOAD.
- done  output  1  one-cycle pulse on completion.
- count  output  ADDR_WIDTH+1  words written in the current or most recent load.
- raddr  input  ADDR_WIDTH  read address.
- q  output  DATA_WIDTH  registered read data.

## Operation
- States: IDLE and LOAD. Reset enters IDLE.
- In IDLE with start=1 and len≠0:
  - latch waddr←base and remaining←len, clear count;
  - go to LOAD next cycle.
- In IDLE with start=1 and len=0:
  - no state change, count←0;
  - done pulses the following cycle.
- In IDLE with start=0: nothing happens. in_valid is ignored and in_ready=0.
- In LOAD, in_ready=1. A transfer occurs on in_valid & in_ready. On each transfer:
  - mem[waddr]←in_data;
  - waddr←(waddr+1) mod DEPTH, so it wraps from DEPTH-1 to 0;
  - remaining←remaining-1;
  - count←count+1.
- If a transfer leaves remaining=0, return to IDLE and pulse done on the next cycle.
- A load with len=DEPTH writes every location exactly once. A base near the top of memory wraps through address 0.
- start while in LOAD is ignored. base and len are not re-sampled.
- abort in LOAD:
  - any transfer in that cycle is suppressed (no write, count unchanged);
  - next state is IDLE, and no done pulse is produced;
  - in_ready still reads 1 that cycle, but the upstream word is not consumed and must be treated as not taken.
  - abort in IDLE has no effect.
- count holds its final value in IDLE until the next accepted start.
- Memory contents are not reset.
- Read port: q←mem[raddr] every cycle, independent of state.

## Timing
- Reset values: state IDLE, in_ready 0, busy 0, done 0, count 0, q 0. Internal waddr and remaining are 0.
- rst_n low mid-load terminates the load immediately. No further writes occur and no done pulse is produced. Words already written remain in memory.
- in_ready and busy are decoded from the registered state only, with no combinational path from in_valid, start or abort.
- Start to in_ready: start sampled at edge N gives in_ready=1 after edge N. The first word can be written at edge N+1.
- Throughput: one word per cycle while in_valid stays high.
- Last transfer at edge M: busy and in_ready drop after M, done=1 for the cycle after M, done=0 after M+1.
- Back-to-back loads: a new start is accepted in the same cycle done is high, since the state is IDLE by then.
- Write/read latency:
  - a word written at edge W is visible on q after edge W+1 when raddr points at it;
  - reading the same address in the write cycle returns the old contents (read-before-write).

## Test plan
- Basic load: base=0x010, len=4, stream A0..A3 with in_valid held → writes at 0x010..0x013, done one cycle after the 4th transfer, count=4. Reading 0x012 then gives q=A2 one cycle later.
- Backpressure: in_valid toggles 1,0,0,1,1,0,1 over len=4 → exactly 4 writes in order, no write on in_valid=0 cycles, done after the last write only.
- Wrap and full depth: base=0x1FE, len=4 → writes to 0x1FE, 0x1FF, 0x000, 0x001. Then len=512 from base=0 with data=address[7:0] → every location verified by readback, count=512.
- Zero length and busy start: start with len=0 → done pulse, no write, count=0. A start during LOAD with different base and len → ignored, original load completes unchanged.
- Abort: len=8, abort asserted with in_valid=1 on the 3rd transfer cycle → 2 writes only, no done, busy=0 the next cycle, count=2.
- Reset mid-load: rst_n low after 3 of 6 words → all outputs reset immediately, 3 words retained in memory. A new load after release behaves normally.
- Read-during-write: raddr equals the current write address → q shows old data that cycle and new data the cycle after.
